// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bundle: hazard/redirect inputs, instruction-memory
// req/ready handshake and the IF/ID pipeline-register drive signals.
interface if_fetch_unit_if;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] ifid_pc;
   logic [31:0] ifid_inst;
   logic        ifid_load;
   logic        ifid_flush;

   // fetch unit side
   modport master (
      input  stall, redirect, redirect_pc, imem_ready, imem_rdata,
      output imem_req, imem_addr, ifid_pc, ifid_inst, ifid_load, ifid_flush
   );

   // memory / pipeline side
   modport slave (
      output stall, redirect, redirect_pc, imem_ready, imem_rdata,
      input  imem_req, imem_addr, ifid_pc, ifid_inst, ifid_load, ifid_flush
   );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a variable-latency
// req/ready handshake, and drives the IF/ID register (load/flush).
// HOLD parks a word returned during a stall; DROP waits out a fetch that
// a redirect has squashed, keeping the address stable until accepted.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            rst,
   if_fetch_unit_if.master bus
);

   typedef enum logic [1:0] {FETCH, HOLD, DROP} state_t;

   state_t      state, state_next;
   logic [31:0] pc, pc_next;
   logic [31:0] inst_buf, inst_buf_next;
   logic [31:0] target_buf, target_buf_next;

   assign bus.imem_addr = pc;
   assign bus.ifid_pc   = pc + 32'd4;

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= FETCH;
         pc         <= RESET_PC;
         inst_buf   <= '0;
         target_buf <= '0;
      end else begin
         state      <= state_next;
         pc         <= pc_next;
         inst_buf   <= inst_buf_next;
         target_buf <= target_buf_next;
      end
   end

   // Next-state and output decode; redirect beats stall beats normal flow
   always_comb begin
      state_next      = state;
      pc_next         = pc;
      inst_buf_next   = inst_buf;
      target_buf_next = target_buf;
      bus.imem_req    = 1'b0;
      bus.ifid_inst   = bus.imem_rdata;
      bus.ifid_load   = 1'b0;
      bus.ifid_flush  = 1'b0;

      case (state)
         FETCH: begin
            bus.imem_req = 1'b1;
            if (bus.redirect) begin
               bus.ifid_flush = 1'b1;
               if (bus.imem_ready) begin
                  pc_next = bus.redirect_pc;
               end else begin
                  target_buf_next = bus.redirect_pc;
                  state_next      = DROP;
               end
            end else if (bus.imem_ready) begin
               if (bus.stall) begin
                  inst_buf_next = bus.imem_rdata;
                  state_next    = HOLD;
               end else begin
                  bus.ifid_load = 1'b1;
                  pc_next       = pc + 32'd4;
               end
            end else if (!bus.stall) begin
               bus.ifid_flush = 1'b1;
            end
         end

         HOLD: begin
            bus.ifid_inst = inst_buf;
            if (bus.redirect) begin
               bus.ifid_flush = 1'b1;
               pc_next        = bus.redirect_pc;
               state_next     = FETCH;
            end else if (!bus.stall) begin
               bus.ifid_load = 1'b1;
               pc_next       = pc + 32'd4;
               state_next    = FETCH;
            end
         end

         DROP: begin
            bus.imem_req = 1'b1;
            if (bus.redirect) begin
               bus.ifid_flush  = 1'b1;
               target_buf_next = bus.redirect_pc;
            end else if (!bus.stall) begin
               bus.ifid_flush = 1'b1;
            end
            // a redirect arriving on the accept cycle overrides the buffered target
            if (bus.imem_ready) begin
               pc_next    = bus.redirect ? bus.redirect_pc : target_buf;
               state_next = FETCH;
            end
         end

         default: state_next = FETCH;
      endcase
   end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage of the 5-stage MIPS pipeline. It sits directly upstream of the IF/ID pipeline register and drives that register's PC, instruction, Load and Flush inputs. It owns the PC and talks to a variable-latency instruction memory over a req/ready handshake. It honours stalls from the hazard unit and branch/jump redirects from ID, including redirects that arrive while a fetch is still outstanding.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
clk  in  1  clock; all state updates on its rising edge.
rst  in  1  asynchronous, active-high reset.
stall  in  1  hazard unit: hold IF/ID and PC this cycle.
redirect  in  1  ID: branch taken or jump; fetch from redirect_pc next.
redirect_pc  in  32  redirect target, word-aligned.
imem_req  out  1  fetch request.
imem_addr  out  32  fetch address; held stable while imem_req=1 until accepted.
imem_ready  in  1  memory returns imem_rdata this cycle; may be high in the same cycle as req (zero-wait).
imem_rdata  in  32  instruction word, valid when imem_ready=1.
ifid_pc  out  32  PC+4 of the delivered instruction, to IF/ID PC input.
ifid_inst  out  32  delivered instruction, to IF/ID instruction input.
ifid_load  out  1  IF/ID Load.
ifid_flush  out  1  IF/ID Flush (synchronous clear, inserts nop bubble).

Behaviour:
- State: pc (32), inst_buf (32), target_buf (32), FSM {FETCH, HOLD, DROP}.
- Reset (async, immediate): pc=RESET_PC, state=FETCH, inst_buf=0, target_buf=0. Outputs during and after reset follow FETCH: imem_req=1, imem_addr=RESET_PC.
- Outputs are combinational from state and inputs. imem_addr=pc always. ifid_pc=pc+4, modulo 2^32 with no overflow detection.
- Handshake: a transaction completes on the cycle with imem_req && imem_ready. The address is never changed while a request is pending.
- "deliver" = ifid_load=1, ifid_flush=0. "bubble" = ifid_load=0, ifid_flush=1. "hold" = both 0. ifid_load and ifid_flush are never both 1.
- Priority within any state: redirect > stall > normal.
- FETCH (imem_req=1, ifid_inst=imem_rdata):
  - redirect & ready: bubble; response discarded; pc<=redirect_pc; stay FETCH.
  - redirect & !ready: bubble; target_buf<=redirect_pc; go DROP.
  - ready & !stall: deliver; pc<=pc+4; stay FETCH.
  - ready & stall: hold; inst_buf<=imem_rdata; go HOLD.
  - !ready & !stall: bubble.
  - !ready & stall: hold.
- HOLD (imem_req=0, ifid_inst=inst_buf):
  - redirect: bubble; buffer discarded; pc<=redirect_pc; go FETCH.
  - stall: hold.
  - otherwise: deliver; pc<=pc+4; go FETCH.
- DROP (imem_req=1, imem_addr=stale pc; fetching a squashed instruction; ifid_inst=imem_rdata, don't-care):
  - Never delivers. stall=1 gives hold; stall=0 gives bubble; redirect gives bubble.
  - redirect while in DROP: target_buf<=redirect_pc; the latest target wins.
  - ready: response discarded; pc<=(redirect ? redirect_pc : target_buf); go FETCH.
- Throughput: a zero-wait memory with no stall delivers one instruction per cycle. An N-cycle memory latency inserts N bubbles.
- Reset mid-transaction abandons any outstanding request. The memory is required to accept the new RESET_PC request.
- Misaligned redirect_pc is not checked; the low bits pass through unchanged.

Test Plan:
1. Reset, ready tied 1, no stall/redirect: imem_addr sequence 0,4,8,12; ifid_load=1 every cycle; ifid_pc=4,8,12,16; ifid_inst equals the memory words.
2. ready asserted 2 cycles after each req: ifid_flush=1 for 2 cycles, then ifid_load=1 for one cycle; imem_addr holds 0x0 until accepted.
3. stall=1 for 3 cycles coinciding with ready at pc=0x8:
   - hold for 3 cycles, imem_req=0 in HOLD.
   - next cycle ifid_load=1 with ifid_inst=word@0x8 and ifid_pc=0xC.
   - following request goes to 0xC.
4. redirect=1, redirect_pc=0x40 while the fetch of 0x10 is pending (ready late by 3 cycles):
   - imem_addr stays 0x10 until ready; ifid_flush=1 throughout; word@0x10 never loaded.
   - next request is 0x40; a second redirect to 0x80 during DROP makes the next request 0x80 instead.
5. redirect and stall high in the same cycle in FETCH with ready=1: ifid_flush=1, ifid_load=0; next imem_addr=redirect_pc.
6. rst asserted mid-wait at pc=0x24 with RESET_PC=0x100: imem_addr=0x100 immediately (async); state=FETCH; inst_buf=0.
